// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bus of the sequential binary-to-BCD converter.
// The requester drives start/bin_in; the converter returns status and result.
interface bin_to_bcd_seq_if #(
    parameter int IN_W = 27
);
    logic            start;
    logic [IN_W-1:0] bin_in;
    logic            busy;
    logic            done;
    logic [31:0]     bcd_out;
    logic            ovf;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, ovf
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, ovf
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary to 8-digit packed BCD converter.
// One bit per cycle: IN_W shift cycles plus one FINISH cycle, result and
// done registered on the edge that leaves FINISH. Values above 99,999,999
// report all-ones digits with ovf set.
module bin_to_bcd_seq #(
    parameter int IN_W = 27
) (
    input  logic              clk,
    input  logic              reset,
    bin_to_bcd_seq_if.slave   bus
);
    localparam int          CNT_W   = $clog2(IN_W + 1);
    localparam logic [31:0] BCD_MAX = 32'd99_999_999;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   cap_q, cap_d;     // untouched copy for the overflow test
    logic [IN_W-1:0]   bin_q, bin_d;     // consumed MSB first by the shifter
    logic [31:0]       scr_q, scr_d;     // BCD scratch, never visible on bcd_out
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [31:0]       adj;

    // Add-3 correction on every scratch digit of 5 or more before the shift.
    always_comb begin
        adj = '0;
        for (int k = 0; k < 8; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
            else
                adj[4*k +: 4] = scr_q[4*k +: 4];
        end
    end

    // Next-state and datapath control; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cap_d   = bus.bin_in;
                    bin_d   = bus.bin_in;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(IN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = (adj << 1) | {31'b0, bin_q[IN_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = FINISH;
            end
            FINISH: begin
                ovf_d   = (32'(cap_q) > BCD_MAX);
                bcd_d   = ovf_d ? 32'hFFFF_FFFF : scr_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cap_q   <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq. Edge 0 is the edge that samples start;
// done is expected after edge 28 and the next start is taken at edge 29.
module tb_bin_to_bcd_seq;
    localparam int IN_W = 27;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.IN_W(IN_W)) bus ();

    bin_to_bcd_seq #(.IN_W(IN_W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // advance n rising edges, leaving the bench 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // start high across exactly one edge (edge 0)
    task automatic go(input logic [IN_W-1:0] v);
        bus.bin_in = v;
        bus.start  = 1'b1;
        step(1);
        bus.start  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        step(3);
        n_vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_status: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        n_vec++;
        if (bus.bcd_out !== 32'h0 || bus.ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_result: bcd=%h ovf=%b want 00000000 0", bus.bcd_out, bus.ovf);
        end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_zero();
        int early;
        early = 0;
        go(0);
        n_vec++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL zero_busy: busy=%b want 1", bus.busy);
        end
        for (int e = 1; e <= 27; e++) begin
            step(1);
            if (bus.done !== 1'b0) early++;
        end
        n_vec++;
        if (early != 0) begin
            n_err++;
            $display("FAIL zero_early_done: %0d early pulses want 0", early);
        end
        step(1);
        n_vec++;
        if (bus.done !== 1'b1 || bus.bcd_out !== 32'h0 || bus.ovf !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_result: done=%b bcd=%h ovf=%b busy=%b want 1 00000000 0 0",
                     bus.done, bus.bcd_out, bus.ovf, bus.busy);
        end
        step(1);
        n_vec++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL zero_done_width: done=%b want 0", bus.done);
        end
    endtask

    task automatic test_values();
        logic [IN_W-1:0] vals [7] = '{27'd12_345_678, 27'd99_999_999, 27'd100_000_000,
                                      27'd5, 27'd134_217_727, 27'd10, 27'd67_108_863};
        logic [31:0] exp_bcd [7] = '{32'h1234_5678, 32'h9999_9999, 32'hFFFF_FFFF,
                                     32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0010,
                                     32'h6710_8863};
        logic        exp_ovf [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] held_bcd;
        logic        held_ovf;
        held_bcd = 32'h0;
        held_ovf = 1'b0;
        for (int i = 0; i < 7; i++) begin
            go(vals[i]);
            step(14);
            n_vec++;
            if (bus.bcd_out !== held_bcd || bus.ovf !== held_ovf) begin
                n_err++;
                $display("FAIL value_hold[%0d]: bcd=%h ovf=%b want %h %b",
                         i, bus.bcd_out, bus.ovf, held_bcd, held_ovf);
            end
            step(13);
            n_vec++;
            if (bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL value_early[%0d]: done=%b at edge 27 want 0", i, bus.done);
            end
            step(1);
            n_vec++;
            if (bus.done !== 1'b1 || bus.bcd_out !== exp_bcd[i] || bus.ovf !== exp_ovf[i]) begin
                n_err++;
                $display("FAIL value[%0d] in=%0d: done=%b bcd=%h ovf=%b want 1 %h %b",
                         i, vals[i], bus.done, bus.bcd_out, bus.ovf, exp_bcd[i], exp_ovf[i]);
            end
            held_bcd = exp_bcd[i];
            held_ovf = exp_ovf[i];
        end
    endtask

    task automatic test_ignore();
        int busy_bad;
        int dones;
        busy_bad = 0;
        dones    = 0;
        go(42);
        if (bus.busy !== 1'b1) busy_bad++;
        step(1);
        bus.bin_in = 9;
        if (bus.busy !== 1'b1) busy_bad++;
        for (int e = 2; e <= 27; e++) begin
            if (e == 10) begin
                bus.start  = 1'b1;
                bus.bin_in = 7;
            end
            step(1);
            if (e == 10) bus.start = 1'b0;
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.done === 1'b1) dones++;
        end
        n_vec++;
        if (busy_bad != 0 || dones != 0) begin
            n_err++;
            $display("FAIL ignore_busy: %0d busy-low cycles %0d early dones want 0 0", busy_bad, dones);
        end
        step(1);
        n_vec++;
        if (bus.done !== 1'b1 || bus.bcd_out !== 32'h0000_0042 || bus.ovf !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_result: done=%b bcd=%h ovf=%b busy=%b want 1 00000042 0 0",
                     bus.done, bus.bcd_out, bus.ovf, bus.busy);
        end
        dones = 0;
        for (int e = 0; e < 40; e++) begin
            step(1);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        n_vec++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL ignore_no_queue: %0d active cycles after done want 0", dones);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        go(77);
        step(15);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== 32'h0 || bus.ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: busy=%b done=%b bcd=%h ovf=%b want 0 0 00000000 0",
                     bus.busy, bus.done, bus.bcd_out, bus.ovf);
        end
        step(2);
        rst_n = 1'b1;
        for (int e = 0; e < 40; e++) begin
            step(1);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        n_vec++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL reset_abort: %0d active cycles after abort want 0", dones);
        end
        dones = 0;
        go(100);
        for (int e = 1; e <= 27; e++) begin
            step(1);
            if (bus.done === 1'b1) dones++;
        end
        step(1);
        n_vec++;
        if (dones != 0 || bus.done !== 1'b1 || bus.bcd_out !== 32'h0000_0100 || bus.ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_restart: early=%0d done=%b bcd=%h ovf=%b want 0 1 00000100 0",
                     dones, bus.done, bus.bcd_out, bus.ovf);
        end
    endtask

    task automatic test_back_to_back();
        int          dones;
        logic [31:0] exp;
        dones      = 0;
        bus.bin_in = 1;
        bus.start  = 1'b1;
        step(1);
        bus.bin_in = 2;
        for (int e = 1; e <= 86; e++) begin
            step(1);
            if (e == 29) bus.bin_in = 3;
            if (e == 58) bus.start = 1'b0;
            if (bus.done === 1'b1) dones++;
            if (e == 28 || e == 57 || e == 86) begin
                exp = (e == 28) ? 32'h1 : (e == 57) ? 32'h2 : 32'h3;
                n_vec++;
                if (bus.done !== 1'b1 || bus.bcd_out !== exp || bus.ovf !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_edge%0d: done=%b bcd=%h ovf=%b want 1 %h 0",
                             e, bus.done, bus.bcd_out, bus.ovf, exp);
                end
            end
        end
        n_vec++;
        if (dones != 3) begin
            n_err++;
            $display("FAIL b2b_count: %0d done pulses want 3", dones);
        end
        step(3);
        n_vec++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_stop: done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_values();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1);
    end
endmodule
